// File: rtl/acc_arb_pkg.sv
// Shared types, constants and the saturating adder for the accumulator
// write-path arbiter. Optional accumulate mode: ACC_ARB_ADD_EN.
package acc_arb_pkg;

    localparam int DATA_W = 8;

    localparam logic signed [7:0] SAT_MAX = 8'sd127;
    // Bit pattern 0x80 is -128 in two's complement.
    localparam logic signed [7:0] SAT_MIN = 8'sh80;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic              ovf;
        logic signed [7:0] sum;
    } sat_res_t;

    // Signed 8-bit add clamped to [-128,127]; ovf flags a clamp.
    function automatic sat_res_t sat_add8(input logic signed [7:0] a,
                                          input logic signed [7:0] b);
        logic signed [8:0] s;
        sat_res_t          r;
        s = {a[7], a} + {b[7], b};
        r.ovf = (s[8] != s[7]);
        if (s[8] != s[7]) begin
            r.sum = s[8] ? SAT_MIN : SAT_MAX;
        end else begin
            r.sum = s[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_win,
    output logic               o_valid
);
    import acc_arb_pkg::*;

    // Scan NUM_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int idx;
        o_win   = '0;
        o_valid = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!o_valid && i_req[idx]) begin
                o_win   = idx[PTR_W-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_arbiter.sv
// Round-robin arbiter sharing the accumulator buffer write path among
// NUM_REQ requesters. Optional accumulate mode: define ACC_ARB_ADD_EN to
// add req_add/acc_rdata/ovf and saturating add-on-write.
module acc_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      hold,
`ifdef ACC_ARB_ADD_EN
    input  logic [NUM_REQ-1:0]        req_add,
    input  logic [DATA_W-1:0]         acc_rdata,
    output logic                      ovf,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      acc_we,
    output logic [DATA_W-1:0]         acc_wdata,
    output logic                      busy
);
    import acc_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                    r_state;
    logic [PTR_W-1:0]          r_ptr;
    logic [NUM_REQ-1:0]        r_gnt;
    logic                      r_we;
    logic                      r_busy;
    logic signed [DATA_W-1:0]  r_data;

    logic [PTR_W-1:0]          w_win;
    logic                      w_valid;
    logic [PTR_W-1:0]          w_next_ptr;
    logic [NUM_REQ-1:0]        w_onehot;
    logic signed [DATA_W-1:0]  w_sel_data;
    logic signed [DATA_W-1:0]  w_load_data;
    logic                      w_load_ovf;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    assign w_sel_data = req_data[int'(w_win)*DATA_W +: DATA_W];
    assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_next_ptr = (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;

`ifdef ACC_ARB_ADD_EN
    logic     r_ovf;
    sat_res_t w_sum;

    assign w_sum = sat_add8(acc_rdata, w_sel_data);

    // Accumulate-mode requesters write the clamped sum instead of raw data.
    always_comb begin
        w_load_data = w_sel_data;
        w_load_ovf  = 1'b0;
        if (req_add[w_win]) begin
            w_load_data = w_sum.sum;
            w_load_ovf  = w_sum.ovf;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_load_data = w_sel_data;
    assign w_load_ovf  = 1'b0;
`endif

    // Two-state FSM: grant and strobe for one cycle, then return to IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
`ifdef ACC_ARB_ADD_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!hold && w_valid) begin
                        r_state <= WRITE;
                        r_gnt   <= w_onehot;
                        r_we    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_data  <= w_load_data;
                        r_ptr   <= w_next_ptr;
`ifdef ACC_ARB_ADD_EN
                        r_ovf   <= w_load_ovf;
`endif
                    end else begin
                        r_gnt   <= '0;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
`ifdef ACC_ARB_ADD_EN
                        r_ovf   <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    // hold is ignored here: a started write always completes.
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef ACC_ARB_ADD_EN
                    r_ovf   <= 1'b0;
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef ACC_ARB_ADD_EN
                    r_ovf   <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign acc_we    = r_we;
    assign acc_wdata = r_data;
    assign busy      = r_busy;

`ifndef ACC_ARB_ADD_EN
    logic w_unused;
    assign w_unused = w_load_ovf;
`endif

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed bench for acc_arbiter with hand-computed expectations.
// Covers ACC_ARB_ADD_EN cases when that macro is defined.
`timescale 1ns/1ps
module tb_acc_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;

    logic                      CLK;
    logic                      RST_N;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      hold;
    logic [NUM_REQ-1:0]        gnt;
    logic                      acc_we;
    logic [DATA_W-1:0]         acc_wdata;
    logic                      busy;
`ifdef ACC_ARB_ADD_EN
    logic [NUM_REQ-1:0]        req_add;
    logic [DATA_W-1:0]         acc_rdata;
    logic                      ovf;
`endif

    int n_chk = 0;
    int n_err = 0;

    acc_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req       (req),
        .req_data  (req_data),
        .hold      (hold),
`ifdef ACC_ARB_ADD_EN
        .req_add   (req_add),
        .acc_rdata (acc_rdata),
        .ovf       (ovf),
`endif
        .gnt       (gnt),
        .acc_we    (acc_we),
        .acc_wdata (acc_wdata),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'h0);
        chk({tag, ".we"}, 32'(acc_we), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    task automatic chk_write(input string tag, input logic [2:0] g, input logic [7:0] d);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".we"}, 32'(acc_we), 32'h1);
        chk({tag, ".wdata"}, 32'(acc_wdata), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'h1);
    endtask

    initial begin
        RST_N    = 1'b0;
        req      = '0;
        req_data = '0;
        hold     = 1'b0;
`ifdef ACC_ARB_ADD_EN
        req_add   = '0;
        acc_rdata = '0;
`endif
        tick();
        tick();
        chk_idle("rst");
        chk("rst.wdata", 32'(acc_wdata), 32'h0);
        RST_N = 1'b1;
        tick();

        // Single requester 1 with 0x7F.
        req      = 3'b010;
        req_data = {8'h00, 8'h7F, 8'h00};
        tick();
        chk_write("single", 3'b010, 8'h7F);
        req = 3'b000;
        tick();
        chk_idle("single_done");
        chk("single_keep", 32'(acc_wdata), 32'h7F);

        // Reset during WRITE (ptr is 2, so 001 wins after wrap).
        req      = 3'b001;
        req_data = {8'h00, 8'h00, 8'h55};
        tick();
        chk_write("pre_rst", 3'b001, 8'h55);
        RST_N = 1'b0;
        req   = 3'b000;
        #1;
        chk_idle("async_rst");
        chk("async_rst.wdata", 32'(acc_wdata), 32'h0);
        tick();
        RST_N = 1'b1;

        // Round-robin from ptr 0 with all requesters held high.
        req      = 3'b111;
        req_data = {8'h03, 8'h02, 8'h01};
        tick();
        chk_write("rr0", 3'b001, 8'h01);
        tick();
        chk_idle("rr0_gap");
        tick();
        chk_write("rr1", 3'b010, 8'h02);
        tick();
        chk_idle("rr1_gap");
        tick();
        chk_write("rr2", 3'b100, 8'h03);
        tick();
        chk_idle("rr2_gap");
        tick();
        chk_write("rr_wrap", 3'b001, 8'h01);
        req = 3'b000;
        tick();
        chk_idle("rr_done");

        // Hold blocks requester 2 for five cycles (ptr is 1).
        hold     = 1'b1;
        req      = 3'b100;
        req_data = {8'h33, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold.gnt", 32'(gnt), 32'h0);
            chk("hold.we", 32'(acc_we), 32'h0);
        end
        hold = 1'b0;
        tick();
        chk_write("hold_rel", 3'b100, 8'h33);
        // Raise hold inside WRITE: the write stays on the outputs.
        hold = 1'b1;
        req  = 3'b000;
        #1;
        chk_write("hold_in_write", 3'b100, 8'h33);
        tick();
        chk_idle("hold_in_write_end");
        hold = 1'b0;

        // Request pulsed only during WRITE is never granted (ptr is 0).
        req      = 3'b010;
        req_data = {8'h00, 8'h44, 8'h11};
        tick();
        chk_write("drop_w", 3'b010, 8'h44);
        req = 3'b001;
        tick();
        req = 3'b000;
        chk_idle("drop_a");
        tick();
        chk_idle("drop_b");
        tick();
        chk_idle("drop_c");

        // Request raised and dropped while hold is high.
        hold = 1'b1;
        req  = 3'b001;
        tick();
        req  = 3'b000;
        hold = 1'b0;
        tick();
        chk_idle("hold_drop_a");
        tick();
        chk_idle("hold_drop_b");
        chk("hold_drop.wdata", 32'(acc_wdata), 32'h44);

`ifdef ACC_ARB_ADD_EN
        // 0x70 + 0x20 = 0x90 > 127, clamps to 0x7F.
        req_add   = 3'b001;
        acc_rdata = 8'h70;
        req_data  = {8'h00, 8'h00, 8'h20};
        req       = 3'b001;
        tick();
        chk_write("add_sat", 3'b001, 8'h7F);
        chk("add_sat.ovf", 32'(ovf), 32'h1);
        req = 3'b000;
        tick();
        chk("add_sat_end.ovf", 32'(ovf), 32'h0);
        // 0x10 + (-16) = 0.
        acc_rdata = 8'h10;
        req_data  = {8'h00, 8'h00, 8'hF0};
        req       = 3'b001;
        tick();
        chk_write("add_plain", 3'b001, 8'h00);
        chk("add_plain.ovf", 32'(ovf), 32'h0);
        req = 3'b000;
        tick();
        // Plain load when req_add is clear.
        req_add  = 3'b000;
        req_data = {8'h00, 8'h00, 8'h90};
        req      = 3'b001;
        tick();
        chk_write("add_off", 3'b001, 8'h90);
        chk("add_off.ovf", 32'(ovf), 32'h0);
        req = 3'b000;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/acc_arbiter.md
Name: acc_arbiter

Overview:
- Shares the single 8-bit signed accumulator write path (accumulator plus its buffer) between NUM_REQ requesters, e.g. ALU writeback, memory load and I/O input.
- Arbitrates round-robin, latches the winner's data and drives a one-cycle write strobe and data into the accumulator buffer.
- Sits between the datapath sources and the accumulator buffer; the control unit can stall arbitration with a hold input.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 8, accumulator data width; fixed at 8, a parameter for readability only.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request bit per requester; held high until granted.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*8+7:i*8]; stable while req[i]=1.
- hold  input  1  control-unit stall; blocks new grants while high.
- gnt  output  NUM_REQ  one-hot grant/acknowledge, high exactly one cycle.
- acc_we  output  1  accumulator buffer write strobe.
- acc_wdata  output  DATA_W  signed data to accumulator buffer.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset, async on RST_N=0: state=IDLE, ptr=0, gnt=0, acc_we=0, acc_wdata=0, busy=0, latched data=0. Any in-flight write is abandoned with no partial strobe.
- FSM has two states, IDLE and WRITE. All outputs are registered.
- IDLE, when hold=0 and req!=0:
  - Winner w = first set bit of req searching upward from ptr, wrapping modulo NUM_REQ.
  - At the next edge: latch req_data[w], set gnt=onehot(w), acc_we=1, acc_wdata=latched data, busy=1, ptr=(w+1) mod NUM_REQ, go to WRITE.
- IDLE, when hold=1 or req=0: remain in IDLE with all strobes 0.
- WRITE lasts one cycle. At the next edge: gnt=0, acc_we=0, busy=0, go to IDLE. acc_wdata keeps its last value.
- Latency and throughput:
  - One cycle from req sampled to gnt/acc_we.
  - At most one write every 2 cycles.
  - Back-to-back requesters alternate fairly.
- Requester protocol:
  - Drop req on the cycle after gnt is seen.
  - A req still high in the IDLE cycle following WRITE is treated as a new request.
- Boundary conditions:
  - A req raised and dropped while hold=1, or while in WRITE, is never granted.
  - Asserting hold during WRITE does not abort the current write; it only blocks the next grant.
  - A request present in the reset-release cycle is arbitrated normally from ptr=0.
  - ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro ACC_ARB_ADD_EN.
- When defined:
  - Extra input req_add [NUM_REQ-1:0] selects accumulate mode per requester.
  - Extra input acc_rdata [7:0] carries the current accumulator value.
  - Extra output ovf, 1 bit, registered.
  - If req_add[w]=1 at grant: acc_wdata = signed saturating sum of acc_rdata and req_data[w], clamped to [-128,127]. ovf=1 for the WRITE cycle when clamping occurs, else 0.
  - If req_add[w]=0: plain load as above.
  - ovf resets to 0.
- When undefined: these three ports are absent and the block performs plain load only.

Decomposition:
- Package acc_arb_pkg holds:
  - state enum (IDLE, WRITE);
  - DATA_W=8;
  - SAT_MAX=8'sd127 and SAT_MIN=-8'sd128;
  - function sat_add8.
- One natural sub-module: rr_picker. It is combinational: inputs req and ptr, outputs winner index and valid. It is instantiated once.

Test Plan:
- Reset: RST_N=0 mid-WRITE, with req=3'b001 and data 0x55 granted last cycle -> gnt=0, acc_we=0, acc_wdata=0x00 immediately (async); after release, ptr=0.
- Single requester: req[1]=1, data1=0x7F -> next cycle gnt=3'b010, acc_we=1, acc_wdata=0x7F; following cycle gnt=0, busy=0.
- Round-robin: req=3'b111 held continuously, data 0x01/0x02/0x03 -> grants in order 001, 010, 100, 001 on alternate cycles, with acc_wdata following 0x01, 0x02, 0x03, 0x01.
- Hold:
  - hold=1 with req=3'b100 for 5 cycles -> no gnt, acc_we=0;
  - hold drops -> gnt=3'b100 one cycle later;
  - hold raised during WRITE -> the write completes.
- Dropped request: req[0] pulsed one cycle during WRITE -> never granted, no acc_we.
- ACC_ARB_ADD_EN: acc_rdata=0x70, data=0x20, req_add=1 -> acc_wdata=0x7F, ovf=1. Then acc_rdata=0x10, data=0xF0 (-16) -> acc_wdata=0x00, ovf=0.
